// File: rtl/ai_tracker.sv
// ============================================================================
// Module   : ai_tracker
// Brief    : Rate-limited computer-player pong paddle; tracks an approaching
//            ball and returns to centre while it recedes.
//            Optional prediction enabled by defining AI_PREDICT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ai_tracker #(
    parameter int COORD_W   = 11,
    parameter int POS_W     = 8,
    parameter int POS_SHIFT = 1,
    parameter int PADDLE_H  = 64,
    parameter int FIELD_H   = 464,
    parameter int MAX_STEP  = 2,
    parameter int DEADZONE  = 1,
    parameter int TICK_DIV  = 500000,
    parameter int LOOKAHEAD = 8
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic               BALL_VALID,
    input  logic [COORD_W-1:0] BALL_H,
    input  logic [COORD_W-1:0] BALL_V,
    output logic [POS_W-1:0]   POSITION,
    output logic [1:0]         STATE,
    output logic               MOVING
);

    localparam int TOP   = FIELD_H - PADDLE_H;
    localparam int TW    = COORD_W + 2;
    localparam int PW    = COORD_W + 6;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [COORD_W-1:0]   HOME_POS = COORD_W'(TOP / 2);
    localparam logic [COORD_W-1:0]   TOP_POS  = COORD_W'(TOP);
    localparam logic signed [PW-1:0] TOP_S    = PW'(TOP);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_HOME  = 2'd2;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [CNT_W-1:0]    tick_cnt;
    logic                tick;
    logic [COORD_W-1:0]  prev_h;
    logic [COORD_W-1:0]  prev_v;
    logic                have_prev;
    logic [COORD_W-1:0]  target;
    logic [COORD_W-1:0]  track_target;
    logic [COORD_W-1:0]  paddle;
    logic [COORD_W-1:0]  paddle_nxt;
    logic signed [TW-1:0] raw_sum;
    logic signed [PW-1:0] want;
    logic signed [TW-1:0] diff;
    logic [TW-1:0]        abs_diff;
    logic [COORD_W-1:0]   step_amt;
    logic                 move;

    assign tick = ENABLE && (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            tick_cnt <= '0;
        end else if (!ENABLE || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            prev_h    <= '0;
            prev_v    <= '0;
            have_prev <= 1'b0;
        end else if (BALL_VALID) begin
            prev_h    <= BALL_H;
            prev_v    <= BALL_V;
            have_prev <= 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (!ENABLE) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_HOME;
                S_HOME:  if (BALL_VALID && have_prev && (BALL_H > prev_h)) state_nxt = S_TRACK;
                S_TRACK: if (BALL_VALID && have_prev && (BALL_H < prev_h)) state_nxt = S_HOME;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        STATE  = state;
        MOVING = move;
    end

    always_comb begin
        raw_sum = $signed({2'b00, BALL_V}) - $signed(TW'(PADDLE_H / 2));
        want    = {{(PW - TW){raw_sum[TW-1]}}, raw_sum};
`ifdef AI_PREDICT_EN
        if (have_prev) begin
            want = $signed({6'b0, BALL_V})
                 + $signed(PW'(LOOKAHEAD)) * ($signed({6'b0, BALL_V}) - $signed({6'b0, prev_v}))
                 - $signed(PW'(PADDLE_H / 2));
        end
`endif
        if (want < 0) begin
            track_target = '0;
        end else if (want > TOP_S) begin
            track_target = TOP_POS;
        end else begin
            track_target = want[COORD_W-1:0];
        end
    end

`ifndef AI_PREDICT_EN
    logic unused_pred;
    assign unused_pred = ^{prev_v, LOOKAHEAD};
`endif

    // Entering or staying in HOME recentres the target; the transition into
    // TRACK already loads the ball-derived target.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            target <= HOME_POS;
        end else if (state_nxt == S_HOME) begin
            target <= HOME_POS;
        end else if ((state_nxt == S_TRACK) && BALL_VALID) begin
            target <= track_target;
        end
    end

    always_comb begin
        diff     = $signed({2'b00, target}) - $signed({2'b00, paddle});
        abs_diff = diff[TW-1] ? -diff : diff;
        step_amt = (abs_diff > TW'(MAX_STEP)) ? COORD_W'(MAX_STEP) : abs_diff[COORD_W-1:0];
        move     = tick && (state != S_IDLE) && (abs_diff > TW'(DEADZONE));
        paddle_nxt = paddle;
        if (move) begin
            paddle_nxt = diff[TW-1] ? (paddle - step_amt) : (paddle + step_amt);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            paddle   <= HOME_POS;
            POSITION <= POS_W'(HOME_POS >> POS_SHIFT);
        end else begin
            paddle   <= paddle_nxt;
            POSITION <= POS_W'(paddle_nxt >> POS_SHIFT);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ai_tracker.sv
// ============================================================================
// Module   : tb_ai_tracker
// Brief    : Directed self-checking bench for ai_tracker (TICK_DIV = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ai_tracker;

    logic        CLOCK;
    logic        RESET;
    logic        ENABLE;
    logic        BALL_VALID;
    logic [10:0] BALL_H;
    logic [10:0] BALL_V;
    logic [7:0]  POSITION;
    logic [1:0]  STATE;
    logic        MOVING;

    int errors = 0;
    int checks = 0;
    int moves  = 0;

    ai_tracker #(
        .TICK_DIV (4)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .BALL_VALID (BALL_VALID),
        .BALL_H     (BALL_H),
        .BALL_V     (BALL_V),
        .POSITION   (POSITION),
        .STATE      (STATE),
        .MOVING     (MOVING)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Both helpers are entered at a falling edge, sample MOVING for the
    // current cycle, then advance one cycle.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (MOVING) moves++;
            @(negedge CLOCK);
        end
    endtask

    task automatic send(input int h, input int v);
        BALL_H     = 11'(h);
        BALL_V     = 11'(v);
        BALL_VALID = 1'b1;
        if (MOVING) moves++;
        @(negedge CLOCK);
        BALL_VALID = 1'b0;
    endtask

    initial begin
        int n;
        RESET      = 1'b0;
        ENABLE     = 1'b0;
        BALL_VALID = 1'b0;
        BALL_H     = '0;
        BALL_V     = '0;
        repeat (2) @(negedge CLOCK);
        chk("reset_pos", POSITION, 100);
        chk("reset_state", STATE, 0);
        chk("reset_moving", MOVING, 0);

        RESET  = 1'b1;
        ENABLE = 1'b1;
        @(negedge CLOCK);
        chk("idle_to_home", STATE, 2);

        // Approaching ball: track to 300-32 = 268
        send(100, 300);
        chk("first_sample_no_trans", STATE, 2);
        send(110, 300);
        chk("approach_track", STATE, 1);
        moves = 0;
        run(160);
        chk("track_moves", moves, 34);
        chk("track_pos", POSITION, 134);
        moves = 0;
        run(8);
        chk("track_settled", moves, 0);

        // Clamp at the top and bottom
        moves = 0;
        send(120, 10);
        run(600);
        chk("clamp_low_moves", moves, 134);
        chk("clamp_low_pos", POSITION, 0);
        chk("clamp_low_state", STATE, 1);
        moves = 0;
        send(130, 460);
        run(850);
        chk("clamp_high_moves", moves, 200);
        chk("clamp_high_pos", POSITION, 200);

        // Receding ball returns paddle home
        send(300, 460);
        chk("approach_keep_track", STATE, 1);
        moves = 0;
        send(290, 460);
        chk("recede_home", STATE, 2);
        send(290, 460);
        chk("same_h_keeps", STATE, 2);
        run(450);
        chk("home_moves", moves, 100);
        chk("home_pos", POSITION, 100);

        // Deadzone: target 235-32 = 203 from 200
        moves = 0;
        send(300, 235);
        run(40);
        chk("dead_moves", moves, 1);
        chk("dead_pos", POSITION, 101);

        ENABLE = 1'b0;
        chk("disable_moving", MOVING, 0);
        run(1);
        chk("disable_idle", STATE, 0);
        moves = 0;
        run(20);
        chk("frozen_pos", POSITION, 101);
        chk("frozen_moves", moves, 0);

        // Tick counter restarted from 0: first step on the 4th cycle
        ENABLE = 1'b1;
        n = 0;
        while (!MOVING && n < 20) begin
            @(negedge CLOCK);
            n++;
        end
        chk("tick_restart_latency", n, 3);
        run(20);
        chk("rehome_pos", POSITION, 100);

        // Asynchronous reset in the middle of a move
        send(310, 400);
        run(20);
        #2;
        RESET = 1'b0;
        #1;
        chk("async_pos", POSITION, 100);
        chk("async_state", STATE, 0);
        chk("async_moving", MOVING, 0);
        repeat (3) @(negedge CLOCK);
        chk("async_hold_pos", POSITION, 100);
        chk("async_hold_state", STATE, 0);
        RESET = 1'b1;
        @(negedge CLOCK);

        // Prediction check: 178 without, 258 with AI_PREDICT_EN
        send(100, 200);
        moves = 0;
        send(110, 210);
        chk("predict_state", STATE, 1);
        run(140);
`ifdef AI_PREDICT_EN
        chk("predict_pos", POSITION, 129);
        chk("predict_moves", moves, 29);
`else
        chk("predict_pos", POSITION, 89);
        chk("predict_moves", moves, 11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ai_tracker.md
Name: ai_tracker

Overview:
Parametrised computer-player paddle controller for pong, the successor to the simple follow-the-ball AI. Paddle is rate-limited: it moves at most MAX_STEP px per movement tick toward a registered target. A three-state FSM tracks the ball while it approaches the AI side and returns the paddle to centre while it recedes. Output is a compressed paddle-top position for the renderer, same format as the previous AI.

Parameters:
COORD_W, 11, width of ball coordinates and internal paddle register
POS_W, 8, width of POSITION output
POS_SHIFT, 1, right shift from paddle px to POSITION (2 px resolution)
PADDLE_H, 64, paddle height in px
FIELD_H, 464, playfield height in px; paddle top range 0..FIELD_H-PADDLE_H
MAX_STEP, 2, max px moved per movement tick
DEADZONE, 1, no movement while |target-paddle| <= DEADZONE
TICK_DIV, 500000, CLOCK cycles per movement tick (>=1)
LOOKAHEAD, 8, prediction frames (used only with AI_PREDICT_EN)

Ports:
CLOCK  input  1  system clock
RESET  input  1  asynchronous, active-low reset
ENABLE  input  1  AI active; low freezes paddle and forces IDLE
BALL_VALID  input  1  one-cycle strobe: BALL_H/BALL_V hold a new ball position (once per frame)
BALL_H  input  COORD_W  ball horizontal position; AI paddle on the right (increasing H = approaching)
BALL_V  input  COORD_W  ball vertical position
POSITION  output  POS_W  (paddle >> POS_SHIFT)[POS_W-1:0], registered
STATE  output  2  FSM state: 0 IDLE, 1 TRACK, 2 HOME
MOVING  output  1  high for the cycle in which a step was applied

Behaviour:
- Reset (RESET low, async): paddle = HOME_POS = (FIELD_H-PADDLE_H)/2 = 200, POSITION = 100, STATE = IDLE, MOVING = 0, tick counter 0, target = HOME_POS, prev_h/prev_v = 0, have_prev = 0.
- Tick counter: counts 0..TICK_DIV-1 while ENABLE high, wraps to 0; tick asserted when count == TICK_DIV-1. Held at 0 when ENABLE low.
- On BALL_VALID: prev_h/prev_v <= BALL_H/BALL_V; have_prev <= 1. Direction compares BALL_H with prev_h only when have_prev = 1.
- Raw target = clamp(BALL_V - PADDLE_H/2, 0, FIELD_H-PADDLE_H); arithmetic signed, COORD_W+2 bits, no wrap on underflow (BALL_V < 32 -> 0; BALL_V > 432 -> 400).
- FSM (state changes only on BALL_VALID, except ENABLE):
  IDLE: ENABLE high -> HOME.
  HOME: target = HOME_POS; BALL_VALID with have_prev and BALL_H > prev_h -> TRACK.
  TRACK: target <= raw target on every BALL_VALID; BALL_VALID with BALL_H < prev_h -> HOME.
  BALL_H == prev_h: state unchanged. First BALL_VALID after reset: no transition.
  ENABLE low in any state -> IDLE next cycle; paddle holds value.
- Movement on tick, state != IDLE: diff = target - paddle (signed). |diff| <= DEADZONE: no move. Otherwise paddle += sign(diff) * min(MAX_STEP, |diff|). MOVING = 1 that cycle. Paddle never leaves 0..FIELD_H-PADDLE_H.
- Tick and BALL_VALID in same cycle: step uses target held before that cycle; new target applies from next cycle.
- Latency: POSITION updates one cycle after the tick cycle in which paddle changes (registered from paddle).

Optional Feature:
AI_PREDICT_EN: when defined, TRACK target = clamp(BALL_V + LOOKAHEAD*(BALL_V - prev_v) - PADDLE_H/2, 0, FIELD_H-PADDLE_H), signed math on COORD_W+6 bits, evaluated only when have_prev = 1 (else raw target). When undefined, target is raw target; prediction logic and LOOKAHEAD are unused.

Test Plan:
- Reset low mid-run -> POSITION = 100, STATE = 0, MOVING = 0 immediately (asynchronous, no clock edge needed); holds until release.
- TICK_DIV=4, ENABLE=1, BALL_VALID with (H=100,V=300) then (H=110,V=300) -> STATE=TRACK, target 268; paddle +2 every 4 cycles; POSITION reaches 134 after 34 ticks, MOVING then stays 0.
- Clamp: in TRACK, V=10 -> paddle settles at 0 (POSITION 0); V=460 -> settles at 400 (POSITION 200); no wrap at either end.
- Receding: from paddle 400, BALL_VALID H=300 then H=290 -> STATE=HOME; paddle returns to 200 at 2 px/tick; same-H sample keeps state.
- Deadzone/step: paddle 200, target 203 -> one step to 202, then |diff| = 1 -> no further move; ENABLE low -> STATE=IDLE, paddle frozen, tick counter 0.
- AI_PREDICT_EN defined: samples (H=100,V=200),(H=110,V=210) -> target = 210+80-32 = 258; undefined -> 178.
